// File: rtl/miss_memory_responder.sv
// Backing line store for instruction and data cache misses: one transaction at a time,
// round-robin arbitration on ties, and a fixed-latency one-cycle response pulse per transaction.
module miss_memory_responder #(
  parameter int LINES   = 64,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  d_wdata,
  output logic [127:0] o_i_line,
  output logic         o_i_valid,
  output logic [127:0] o_d_line,
  output logic         o_d_valid,
  output logic         o_busy
);

  localparam int IW = $clog2(LINES);
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ptrI_q, ptrI_d;
  logic            portI_q, portI_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [127:0]    iLine_q, iLine_d;
  logic [127:0]    dLine_q, dLine_d;
  logic [3:0][31:0] mem_q [LINES];

  logic            accept;
  logic            grantI;
  logic            memWe;
  logic [IW-1:0]   iIdx;
  logic [IW-1:0]   dIdx;
  logic [1:0]      dWord;
  logic            unused_addr;

  assign iIdx   = i_addr[3+IW:4];
  assign dIdx   = d_addr[3+IW:4];
  assign dWord  = d_addr[3:2];
  assign grantI = i_req && (!d_req || ptrI_q);
  assign accept = (state_q == IDLE) && (i_req || d_req);
  assign memWe  = accept && !grantI && d_we && !rstn;

  assign unused_addr = ^{i_addr[31:4+IW], i_addr[3:0], d_addr[31:4+IW], d_addr[1:0]};

  assign o_busy    = (state_q != IDLE);
  assign o_i_valid = (state_q == RESP) && portI_q;
  assign o_d_valid = (state_q == RESP) && !portI_q;
  assign o_i_line  = iLine_q;
  assign o_d_line  = dLine_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptrI_d  = ptrI_q;
    portI_d = portI_q;
    idx_d   = idx_q;
    iLine_d = iLine_q;
    dLine_d = dLine_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
          portI_d = grantI;
          idx_d   = grantI ? iIdx : dIdx;
          if (i_req && d_req) ptrI_d = !ptrI_q;
        end
      end
      WAIT: begin
        // The line is captured on entry to RESP so a write response already carries its new word.
        if (cnt_q == '0) begin
          state_d = RESP;
          if (portI_q) iLine_d = mem_q[idx_q];
          else         dLine_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptrI_q  <= 1'b0;
      portI_q <= 1'b0;
      idx_q   <= '0;
      iLine_q <= '0;
      dLine_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptrI_q  <= ptrI_d;
      portI_q <= portI_d;
      idx_q   <= idx_d;
      iLine_q <= iLine_d;
      dLine_q <= dLine_d;
    end
  end

  // Storage is deliberately outside the reset domain; a write commits at its acceptance edge.
  always_ff @(posedge clk) begin
    if (memWe) mem_q[dIdx][dWord] <= d_wdata;
  end

endmodule

// File: tb/tb_miss_memory_responder.sv
// Scoreboard bench for miss_memory_responder: expectations are pushed at acceptance
// from a bench-side line model and popped when a valid pulse appears.
module tb_miss_memory_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rstn;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [31:0]  d_wdata;
  logic [127:0] o_i_line;
  logic         o_i_valid;
  logic [127:0] o_d_line;
  logic         o_d_valid;
  logic         o_busy;

  miss_memory_responder #(.LINES(64), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .o_i_line  (o_i_line),
    .o_i_valid (o_i_valid),
    .o_d_line  (o_d_line),
    .o_d_valid (o_d_valid),
    .o_busy    (o_busy)
  );

  typedef struct {
    logic         isI;
    logic [127:0] line;
    logic [127:0] mask;
    int           cyc;
  } exp_t;

  exp_t         sbQ[$];
  logic [127:0] lineModel [64];
  logic [3:0]   known [64];
  logic         tbPtrI;
  int           cyc;
  int           respCount;
  int           testsRun;
  int           testsFailed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every valid pulse is matched against the oldest expectation: port, exact cycle and line.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn && (o_i_valid || o_d_valid)) begin
      respCount++;
      checkOutput("oneValid", {127'd0, o_i_valid & o_d_valid}, 128'd0);
      if (sbQ.size() == 0) begin
        checkOutput("spuriousValid", {126'd0, o_i_valid, o_d_valid}, 128'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("port", {127'd0, o_i_valid}, {127'd0, e.isI});
        checkOutput("latency", 128'(cyc), 128'(e.cyc));
        checkOutput("line", (e.isI ? o_i_line : o_d_line) & e.mask, e.line & e.mask);
      end
    end
  end

  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data);
    int idx;
    int w;
    idx = int'(addr[9:4]);
    w   = int'(addr[3:2]);
    lineModel[idx][32*w +: 32] = data;
    known[idx][w] = 1'b1;
  endtask

  task automatic expectResp(input logic isI, input logic [31:0] addr, input int accCyc);
    exp_t e;
    int   idx;
    idx    = int'(addr[9:4]);
    e.isI  = isI;
    e.line = lineModel[idx];
    e.mask = '0;
    for (int w = 0; w < 4; w++) e.mask[32*w +: 32] = {32{known[idx][w]}};
    e.cyc  = accCyc + LAT;
    sbQ.push_back(e);
  endtask

  task automatic waitAccept(output int accCyc);
    accCyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (o_busy) begin
        accCyc = cyc;
        break;
      end
    end
    if (accCyc < 0) checkOutput("acceptTimeout", {127'd0, o_busy}, 128'd1);
  endtask

  task automatic waitRespThenIdle(input int startCount);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (respCount != startCount) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("respTimeout", 128'(respCount), 128'(startCount + 1));
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!o_busy) break;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // Drives one request pattern, predicts the grant, and scrambles the inputs once accepted.
  task automatic applyStimulus(input logic iReq, input logic dReq, input logic we,
                               input logic [31:0] iAddr, input logic [31:0] dAddr,
                               input logic [31:0] wdata);
    int   acc;
    int   rc;
    logic gI;
    i_req   = iReq;
    d_req   = dReq;
    d_we    = we;
    i_addr  = iAddr;
    d_addr  = dAddr;
    d_wdata = wdata;
    rc      = respCount;
    waitAccept(acc);
    gI = iReq && (!dReq || tbPtrI);
    if (iReq && dReq) tbPtrI = !tbPtrI;
    if (!gI && we) modelWrite(dAddr, wdata);
    expectResp(gI, gI ? iAddr : dAddr, acc);
    i_addr  = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_we    = 1'($urandom);
    waitRespThenIdle(rc);
  endtask

  initial begin
    int acc;
    int rc;
    logic [31:0] a;
    logic [31:0] dt;
    cyc = 0;
    respCount = 0;
    testsRun = 0;
    testsFailed = 0;
    tbPtrI = 1'b0;
    for (int i = 0; i < 64; i++) begin
      lineModel[i] = '0;
      known[i] = '0;
    end
    rstn = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", {127'd0, o_busy}, 128'd0);
    checkOutput("rstIValid", {127'd0, o_i_valid}, 128'd0);
    checkOutput("rstDValid", {127'd0, o_d_valid}, 128'd0);
    checkOutput("rstILine", o_i_line, 128'd0);
    checkOutput("rstDLine", o_d_line, 128'd0);
    rstn = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h00430820);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 32'h00000020);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h8, 32'h00000020);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'hC, 32'h00000020);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    checkOutput("fullLine", o_i_line, {32'h00000020, 32'h00000020, 32'h00000020, 32'h00430820});

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'h11111111);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 32'h10, 32'hBAD0BAD0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h400, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("aliasWord0", {96'd0, o_i_line[31:0]}, {96'd0, 32'hDEADBEEF});
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFC08, 32'h0);

    for (int k = 0; k < 6; k++) begin
      a  = {24'($urandom), 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      dt = $urandom;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, a, dt);
      applyStimulus(1'b1, 1'b0, 1'b0, a ^ 32'h0000000C, 32'h0, 32'h0);
    end

    // A request appearing only while busy, and withdrawn before IDLE, must never be served.
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h0;
    rc = respCount;
    waitAccept(acc);
    expectResp(1'b0, 32'h0, acc);
    @(negedge clk);
    i_req = 1'b1;
    i_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    i_req = 1'b0;
    waitRespThenIdle(rc);
    repeat (8) @(negedge clk);
    checkOutput("noExtraResp", 128'(respCount), 128'(rc + 1));
    checkOutput("idleAfterBusyReq", {127'd0, o_busy}, 128'd0);

    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'hCAFEF00D;
    waitAccept(acc);
    modelWrite(32'h20, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    #1;
    checkOutput("abortBusy", {127'd0, o_busy}, 128'd0);
    checkOutput("abortValids", {126'd0, o_i_valid, o_d_valid}, 128'd0);
    checkOutput("abortILine", o_i_line, 128'd0);
    checkOutput("abortDLine", o_d_line, 128'd0);
    d_req = 1'b0;
    d_we = 1'b0;
    tbPtrI = 1'b0;
    rc = respCount;
    @(negedge clk);
    rstn = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("noRespAfterAbort", 128'(respCount), 128'(rc));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0);
    checkOutput("committedWrite", {96'd0, o_d_line[31:0]}, {96'd0, 32'hCAFEF00D});

    repeat (4) @(negedge clk);
    checkOutput("sbEmpty", 128'(sbQ.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/miss_memory_responder.md
MISS_MEMORY_RESPONDER -- requirements
Module: miss_memory_responder

Interface
REQ-001 SHALL have parameter LINES, default 64, meaning number of 128-bit lines stored (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to response (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-high (despite the name).
REQ-005 SHALL have port i_req  input  1  instruction-cache line-miss request.
REQ-006 SHALL have port i_addr  input  32  instruction miss byte address.
REQ-007 SHALL have port d_req  input  1  data-cache request.
REQ-008 SHALL have port d_we  input  1  data request is a word write when 1, a line read when 0.
REQ-009 SHALL have port d_addr  input  32  data byte address.
REQ-010 SHALL have port d_wdata  input  32  write word.
REQ-011 SHALL have port o_i_line  output  128  line returned to the instruction cache.
REQ-012 SHALL have port o_i_valid  output  1  one-cycle pulse qualifying o_i_line.
REQ-013 SHALL have port o_d_line  output  128  line returned to the data cache.
REQ-014 SHALL have port o_d_valid  output  1  one-cycle pulse qualifying o_d_line; also the write acknowledge.
REQ-015 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; IDLE->WAIT on acceptance, WAIT->RESP when the latency counter expires, RESP->IDLE unconditionally.
REQ-017 SHALL accept a request only at a rising edge in IDLE with i_req or d_req high; requests in WAIT/RESP are ignored, not queued.
REQ-018 SHALL arbitrate simultaneous i_req and d_req round-robin; after reset the first tie goes to data; the grant pointer toggles only on a tie.
REQ-019 SHALL latch port, address, we and wdata at acceptance; later input changes do not affect the transaction.
REQ-020 SHALL index the line by addr[3+log2(LINES):4]; upper address bits ignored (aliasing wrap-around); addr[1:0] ignored.
REQ-021 SHALL, for a write, replace word addr[3:2] of the indexed line at the acceptance edge; other words unchanged.
REQ-022 SHALL pack word k of a line at bits [32k+31:32k] (word 0 in bits 31:0).
REQ-023 SHALL raise exactly one valid (o_i_valid or o_d_valid, per the granted port) for exactly one cycle, LATENCY cycles after the acceptance edge (acceptance edge T, valid high during cycle T+LATENCY).
REQ-024 SHALL drive the granted line output with the indexed line as of the response cycle (write responses return the updated line).
REQ-025 SHALL hold each line output at its last driven value between responses; o_i_line/o_d_line undefined-free (0 after reset).
REQ-026 SHALL re-accept a request still held high in the cycle after RESP as a new transaction; requesters drop req in the cycle valid is seen.
REQ-027 SHALL require d_we be ignored when the instruction port is granted.

Reset
REQ-028 SHALL, on rstn high, asynchronously force state IDLE, counter 0, o_i_valid=0, o_d_valid=0, o_busy=0, o_i_line=0, o_d_line=0, grant pointer = data.
REQ-029 SHALL abort any in-flight transaction on reset with no valid pulse afterwards; an in-flight write already committed at acceptance remains.
REQ-030 SHALL leave the line storage contents unaffected by reset.

Verification
REQ-031 SHALL verify: d write addr 0x0 data 0x00430820 at T -> o_d_valid only at T+4, o_d_line[31:0]=0x00430820.
REQ-032 SHALL verify: after writes 0x00000020 to 0x4, 0x8, 0xC, i read addr 0x0 -> o_i_line = {0x00000020,0x00000020,0x00000020,0x00430820} at T+4.
REQ-033 SHALL verify: i_req and d_req raised together twice -> first served data, second instruction; each valid 4 cycles after its acceptance, never overlapping.
REQ-034 SHALL verify aliasing: write 0xDEADBEEF to 0x400 (LINES=64) -> read 0x0 returns 0xDEADBEEF in word 0.
REQ-035 SHALL verify: rstn pulsed 2 cycles after acceptance -> no valid ever pulses, outputs 0, o_busy 0 immediately.
REQ-036 SHALL verify: requests arriving while o_busy=1 and dropped before IDLE -> no response generated.
